// File: rtl/intdiv_pkg.sv
// intdiv_pkg: shared SD2 digit, sign and FSM state encodings for the radix-2 non-restoring divider.
package intdiv_pkg;
    typedef enum logic [1:0] {
        ZERO   = 2'b00,
        POS1_1 = 2'b01,
        POS1_2 = 2'b10,
        NEG1   = 2'b11
    } sd2_t;
    localparam logic NEGATIVE = 1'b1;
    localparam logic POSITIVE = 1'b0;
    typedef enum logic [2:0] {IDLE, ITER, CORR, FIX, DONE} state_t;
endpackage

// File: rtl/intdiv_ctrl_if.sv
// intdiv_ctrl_if: issue/result handshake and SD2 digit stream of the divider controller.
interface intdiv_ctrl_if #(parameter int W = 8);
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         ready;
    logic [W-1:0] quot;
    logic [W-1:0] rem;
    logic         div_by_zero;
    logic         valid;
    logic         out_ready;
    logic [1:0]   q_digit;
    logic         q_digit_vld;
    logic         rem_sign;
    modport master (output start, dividend, divisor, out_ready,
                    input ready, quot, rem, div_by_zero, valid, q_digit, q_digit_vld, rem_sign);
    modport slave  (input start, dividend, divisor, out_ready,
                    output ready, quot, rem, div_by_zero, valid, q_digit, q_digit_vld, rem_sign);
endinterface

// File: rtl/intdiv_step.sv
// intdiv_step: one combinational non-restoring iteration on the W+1 bit signed partial remainder.
module intdiv_step import intdiv_pkg::*; #(parameter int W = 8) (
    input  logic [W:0]   i_r,
    input  logic         i_a,
    input  logic [W-1:0] i_d,
    input  logic         i_sign,
    output logic [W:0]   o_r,
    output logic         o_q,
    output logic [1:0]   o_digit
);
    logic [W:0] w_sh;
    logic [W:0] w_d;
    always_comb begin
        w_sh    = {i_r[W-1:0], i_a};
        w_d     = {1'b0, i_d};
        o_r     = (i_sign == NEGATIVE) ? w_sh + w_d : w_sh - w_d;
        o_q     = ~o_r[W];
        o_digit = (i_sign == NEGATIVE) ? NEG1 : POS1_1;
    end
endmodule

// File: rtl/intdiv_ctrl.sv
// intdiv_ctrl: iterative radix-2 non-restoring divider controller with SD2 digit output.
// Optional INTDIV_CTRL_SIGNED_EN: two's complement operands, truncating division via an extra FIX state.
module intdiv_ctrl import intdiv_pkg::*; #(parameter int W = 8) (
    input logic         clk,
    input logic         rst_n,
    intdiv_ctrl_if.slave bus
);
    localparam int CW = (W > 2) ? $clog2(W) : 1;
`ifdef INTDIV_CTRL_SIGNED_EN
    localparam state_t S_AFTER_CORR = FIX;
`else
    localparam state_t S_AFTER_CORR = DONE;
`endif
    state_t        r_state, w_next;
    logic [W:0]    r_r, w_r;
    logic [W-1:0]  r_a, r_d, r_q, r_quot, r_rem, w_ua, w_ud;
    logic [CW-1:0] r_i;
    logic          r_sign, r_dbz, w_qbit;
    logic [1:0]    w_digit;
`ifdef INTDIV_CTRL_SIGNED_EN
    logic          r_sa, r_sd;
    assign w_ua = bus.dividend[W-1] ? -bus.dividend : bus.dividend;
    assign w_ud = bus.divisor[W-1] ? -bus.divisor : bus.divisor;
`else
    assign w_ua = bus.dividend;
    assign w_ud = bus.divisor;
`endif

    intdiv_step #(.W(W)) u_step (
        .i_r(r_r), .i_a(r_a[W-1]), .i_d(r_d), .i_sign(r_sign),
        .o_r(w_r), .o_q(w_qbit), .o_digit(w_digit)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = (bus.divisor == '0) ? DONE : ITER;
            ITER:    if (r_i == '0) w_next = CORR;
            CORR:    w_next = S_AFTER_CORR;
            FIX:     w_next = DONE;
            DONE:    if (bus.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_r    <= '0;
            r_a    <= '0;
            r_d    <= '0;
            r_q    <= '0;
            r_i    <= '0;
            r_sign <= POSITIVE;
            r_quot <= '0;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
`ifdef INTDIV_CTRL_SIGNED_EN
            r_sa   <= 1'b0;
            r_sd   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: if (bus.start) begin
                    r_a    <= w_ua;
                    r_d    <= w_ud;
                    r_r    <= '0;
                    r_i    <= CW'(W - 1);
                    r_sign <= POSITIVE;
`ifdef INTDIV_CTRL_SIGNED_EN
                    r_sa   <= bus.dividend[W-1];
                    r_sd   <= bus.divisor[W-1];
`endif
                    if (bus.divisor == '0) begin
                        r_quot <= '1;
                        r_rem  <= bus.dividend;
                        r_dbz  <= 1'b1;
                    end
                end
                ITER: begin
                    r_r    <= w_r;
                    r_a    <= r_a << 1;
                    r_q    <= {r_q[W-2:0], w_qbit};
                    r_sign <= w_r[W];
                    r_i    <= r_i - 1'b1;
                end
                CORR: begin
                    r_quot <= r_q;
                    r_rem  <= r_r[W] ? r_r[W-1:0] + r_d : r_r[W-1:0];
                    r_dbz  <= 1'b0;
                end
`ifdef INTDIV_CTRL_SIGNED_EN
                FIX: begin
                    r_quot <= (r_sa ^ r_sd) ? -r_quot : r_quot;
                    r_rem  <= r_sa ? -r_rem : r_rem;
                end
`endif
                default: ;
            endcase
        end

    // ready is masked by rst_n so it reads 0 for the whole reset window
    assign bus.ready       = rst_n && (r_state == IDLE);
    assign bus.valid       = (r_state == DONE);
    assign bus.quot        = r_quot;
    assign bus.rem         = r_rem;
    assign bus.div_by_zero = r_dbz;
    assign bus.q_digit     = (r_state == ITER) ? w_digit : ZERO;
    assign bus.q_digit_vld = (r_state == ITER);
    assign bus.rem_sign    = r_sign;
endmodule

// File: tb/tb_intdiv_ctrl.sv
// tb_intdiv_ctrl: randomized and directed checks of intdiv_ctrl against a plain-arithmetic division model.
module tb_intdiv_ctrl;
    import intdiv_pkg::*;
    localparam int W = 8;
`ifdef INTDIV_CTRL_SIGNED_EN
    localparam int LAT = W + 3;
`else
    localparam int LAT = W + 2;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;

    intdiv_ctrl_if #(.W(W)) bus ();
    intdiv_ctrl #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] d,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        int sa, sd;
        sa = 0;
        sd = 0;
        if (d == '0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
`ifdef INTDIV_CTRL_SIGNED_EN
            sa = int'($signed(a));
            sd = int'($signed(d));
            q = W'(sa / sd);
            r = W'(sa % sd);
`else
            sa = int'(a);
            sd = int'(d);
            q = W'(sa / sd);
            r = W'(sa % sd);
`endif
            z = 1'b0;
        end
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] d, input bit noise,
                          output int lat, output int pulses, output logic [1:0] dig0);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        bus.start = 1'b1;
        bus.dividend = a;
        bus.divisor = d;
        @(posedge clk);
        #1;
        bus.start = noise;
        bus.dividend = W'($urandom);
        bus.divisor = W'($urandom);
        lat = 1;
        pulses = 0;
        dig0 = bus.q_digit;
        while (bus.valid !== 1'b1 && lat < 100) begin
            if (bus.q_digit_vld === 1'b1) pulses++;
            @(posedge clk);
            #1;
            lat++;
        end
        bus.start = 1'b0;
    endtask

    task automatic pop;
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({bus.ready, bus.quot, bus.rem, bus.div_by_zero, bus.valid, bus.q_digit, bus.q_digit_vld, bus.rem_sign} !== '0) begin
            fails++;
            $display("FAIL reset_hold: ready=%b quot=%0d rem=%0d dbz=%b valid=%b dig=%b vld=%b sign=%b, want all 0",
                     bus.ready, bus.quot, bus.rem, bus.div_by_zero, bus.valid, bus.q_digit, bus.q_digit_vld, bus.rem_sign);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if ({bus.ready, bus.valid, bus.q_digit_vld, bus.q_digit} !== 5'b10000) begin
            fails++;
            $display("FAIL reset_idle: ready=%b valid=%b vld=%b dig=%b, want ready=1 others 0",
                     bus.ready, bus.valid, bus.q_digit_vld, bus.q_digit);
        end
    endtask

    task automatic test_basic;
        int lat, pulses;
        logic [1:0] dig0;
        run_op(8'd100, 8'd7, 1'b0, lat, pulses, dig0);
        tests++;
        if (lat !== LAT) begin
            fails++;
            $display("FAIL basic_latency: got %0d want %0d", lat, LAT);
        end
        tests++;
        if ({bus.quot, bus.rem, bus.div_by_zero} !== {8'd14, 8'd2, 1'b0}) begin
            fails++;
            $display("FAIL basic_result: quot=%0d rem=%0d dbz=%b want 14 2 0", bus.quot, bus.rem, bus.div_by_zero);
        end
        tests++;
        if (pulses !== W) begin
            fails++;
            $display("FAIL basic_pulses: got %0d want %0d", pulses, W);
        end
        tests++;
        if (dig0 !== POS1_1) begin
            fails++;
            $display("FAIL basic_first_digit: got %b want %b", dig0, POS1_1);
        end
        pop();
    endtask

    task automatic test_corners;
        logic [W-1:0] as [4];
        logic [W-1:0] ds [4];
        logic [W-1:0] eq, er;
        logic ez;
        int lat, pulses;
        logic [1:0] dig0;
        as = '{8'd7, 8'd255, 8'd255, 8'd1};
        ds = '{8'd100, 8'd1, 8'd255, 8'd200};
        for (int k = 0; k < 4; k++) begin
            model(as[k], ds[k], eq, er, ez);
            run_op(as[k], ds[k], 1'b0, lat, pulses, dig0);
            tests++;
            if ({bus.quot, bus.rem, bus.div_by_zero, lat} !== {eq, er, ez, LAT}) begin
                fails++;
                $display("FAIL corner_%0d_%0d: quot=%0d rem=%0d dbz=%b lat=%0d want %0d %0d %b %0d",
                         as[k], ds[k], bus.quot, bus.rem, bus.div_by_zero, lat, eq, er, ez, LAT);
            end
            pop();
        end
    endtask

    task automatic test_div_zero;
        int lat, pulses;
        logic [1:0] dig0;
        run_op(8'd5, 8'd0, 1'b0, lat, pulses, dig0);
        tests++;
        if ({bus.quot, bus.rem, bus.div_by_zero, lat, pulses} !== {8'hFF, 8'd5, 1'b1, 32'd1, 32'd0}) begin
            fails++;
            $display("FAIL div_zero: quot=%h rem=%0d dbz=%b lat=%0d pulses=%0d want ff 5 1 1 0",
                     bus.quot, bus.rem, bus.div_by_zero, lat, pulses);
        end
        pop();
    endtask

    task automatic test_hold;
        logic [W-1:0] eq, er;
        logic ez;
        int lat, pulses;
        logic [1:0] dig0;
        model(8'd200, 8'd13, eq, er, ez);
        run_op(8'd200, 8'd13, 1'b1, lat, pulses, dig0);
        tests++;
        if ({bus.quot, bus.rem, lat, pulses} !== {eq, er, LAT, W}) begin
            fails++;
            $display("FAIL hold_result: quot=%0d rem=%0d lat=%0d pulses=%0d want %0d %0d %0d %0d",
                     bus.quot, bus.rem, lat, pulses, eq, er, LAT, W);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus.start = 1'b1;
            bus.dividend = W'($urandom);
            bus.divisor = W'($urandom);
            @(posedge clk);
            #1;
            tests++;
            if ({bus.valid, bus.ready, bus.quot, bus.rem} !== {1'b1, 1'b0, eq, er}) begin
                fails++;
                $display("FAIL hold_stable_%0d: valid=%b ready=%b quot=%0d rem=%0d want 1 0 %0d %0d",
                         k, bus.valid, bus.ready, bus.quot, bus.rem, eq, er);
            end
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.start = 1'b0;
        tests++;
        if ({bus.ready, bus.valid} !== 2'b10) begin
            fails++;
            $display("FAIL hold_release: ready=%b valid=%b want 1 0", bus.ready, bus.valid);
        end
        @(posedge clk);
        #1;
        tests++;
        if (bus.ready !== 1'b1) begin
            fails++;
            $display("FAIL hold_no_accept: ready=%b want 1", bus.ready);
        end
    endtask

    task automatic test_reset_mid;
        int lat, pulses;
        logic [1:0] dig0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = 8'd100;
        bus.divisor = 8'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.ready, bus.quot, bus.rem, bus.div_by_zero, bus.valid, bus.q_digit, bus.q_digit_vld, bus.rem_sign} !== '0) begin
            fails++;
            $display("FAIL reset_mid: ready=%b quot=%0d rem=%0d dbz=%b valid=%b dig=%b vld=%b sign=%b, want all 0",
                     bus.ready, bus.quot, bus.rem, bus.div_by_zero, bus.valid, bus.q_digit, bus.q_digit_vld, bus.rem_sign);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'd9, 8'd2, 1'b0, lat, pulses, dig0);
        tests++;
        if ({bus.quot, bus.rem, bus.div_by_zero, lat} !== {8'd4, 8'd1, 1'b0, LAT}) begin
            fails++;
            $display("FAIL reset_mid_next: quot=%0d rem=%0d dbz=%b lat=%0d want 4 1 0 %0d",
                     bus.quot, bus.rem, bus.div_by_zero, lat, LAT);
        end
        pop();
    endtask

`ifdef INTDIV_CTRL_SIGNED_EN
    task automatic test_signed;
        int lat, pulses;
        logic [1:0] dig0;
        run_op(8'(-100), 8'd7, 1'b0, lat, pulses, dig0);
        tests++;
        if ({bus.quot, bus.rem, lat} !== {8'(-14), 8'(-2), 32'(W + 3)}) begin
            fails++;
            $display("FAIL signed_neg100_7: quot=%h rem=%h lat=%0d want f2 fe %0d", bus.quot, bus.rem, lat, W + 3);
        end
        pop();
        run_op(8'h80, 8'hFF, 1'b0, lat, pulses, dig0);
        tests++;
        if ({bus.quot, bus.rem, bus.div_by_zero} !== {8'h80, 8'h00, 1'b0}) begin
            fails++;
            $display("FAIL signed_min_neg1: quot=%h rem=%h dbz=%b want 80 00 0", bus.quot, bus.rem, bus.div_by_zero);
        end
        pop();
    endtask
`endif

    task automatic test_back_to_back;
        logic [W-1:0] a, d, eq, er;
        logic ez;
        int lat, pulses, elat, ep;
        logic [1:0] dig0;
        for (int k = 0; k < 40; k++) begin
            a = W'($urandom);
            d = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            model(a, d, eq, er, ez);
            elat = ez ? 1 : LAT;
            ep = ez ? 0 : W;
            run_op(a, d, k[0], lat, pulses, dig0);
            tests++;
            if ({bus.quot, bus.rem, bus.div_by_zero, lat, pulses} !== {eq, er, ez, elat, ep}) begin
                fails++;
                $display("FAIL rand_%0d (%0d/%0d): quot=%0d rem=%0d dbz=%b lat=%0d pulses=%0d want %0d %0d %b %0d %0d",
                         k, a, d, bus.quot, bus.rem, bus.div_by_zero, lat, pulses, eq, er, ez, elat, ep);
            end
            pop();
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_corners();
        test_div_zero();
        test_hold();
        test_reset_mid();
`ifdef INTDIV_CTRL_SIGNED_EN
        test_signed();
`endif
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
